// File: rtl/read_fmps_test_link.sv
// Receive-side checker for 2-beat FMPS test packets (header, data) on the Aurora user clock.
// Optional build macro SEQUENCE_CHECK_EN adds cycle/index continuity checks between good packets.
module read_fmps_test_link #(
  parameter logic [15:0] HEADER_MAGIC     = 16'hB6CF,
  parameter logic [15:0] DATA_PATTERN     = 16'hCACA,
  parameter int          FMPS_INDEX_WIDTH = 5,
  parameter int          ERR_COUNT_WIDTH  = 16
) (
  input  logic                       auroraUserClk,
  input  logic                       auroraReset_n,
  input  logic                       auroraChannelUp,
  input  logic [31:0]                FMPS_TEST_AXI_STREAM_RX_tdata,
  input  logic                       FMPS_TEST_AXI_STREAM_RX_tvalid,
  input  logic                       FMPS_TEST_AXI_STREAM_RX_tlast,
  output logic                       FMPS_TEST_AXI_STREAM_RX_tready,
  input  logic                       clearCounters,
  output logic                       statusStrobe,
  output logic [1:0]                 statusCode,
  output logic [4:0]                 rxFmpsIndex,
  output logic [7:0]                 rxFAcycle,
  output logic [31:0]                goodCount,
  output logic [ERR_COUNT_WIDTH-1:0] errorCount,
  output logic [1:0]                 dbgState
);

  if (FMPS_INDEX_WIDTH != 5) begin : gBadIndexWidth
    $error("read_fmps_test_link: only FMPS_INDEX_WIDTH = 5 is supported");
  end

  typedef enum logic [1:0] {
    WAIT_HEADER = 2'd0,
    WAIT_DATA   = 2'd1,
    DISCARD     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CODE_OK      = 2'd0,
    CODE_HEADER  = 2'd1,
    CODE_DATA    = 2'd2,
    CODE_FRAMING = 2'd3
  } code_t;

  state_t state, stateNext;
  code_t  code;
  logic   beat, decide, latchHdr, goodData, reseed, seqFail;
  logic [4:0] hdrIndex;

  wire [31:0] tdata    = FMPS_TEST_AXI_STREAM_RX_tdata;
  wire        tlast    = FMPS_TEST_AXI_STREAM_RX_tlast;
  wire [4:0]  dIndex   = tdata[28:24];
  wire [7:0]  dCycle   = tdata[7:0];
  wire        hdrBad   = (tdata[31:16] != HEADER_MAGIC) || !tdata[15];
  wire        dataBad  = (tdata[31:29] != 3'b000) || (dIndex != hdrIndex) ||
                         (tdata[23:8] != DATA_PATTERN);

  assign FMPS_TEST_AXI_STREAM_RX_tready = auroraChannelUp;
  assign beat     = FMPS_TEST_AXI_STREAM_RX_tvalid && auroraChannelUp;
  assign dbgState = state;

`ifdef SEQUENCE_CHECK_EN
  // Continuity is only meaningful once a good packet has seeded the reference.
  logic seeded;
  always_comb begin
    seqFail = 1'b0;
    if (seeded) begin
      if (dCycle != rxFAcycle && dCycle != rxFAcycle + 8'd1)
        seqFail = 1'b1;
      else if (dCycle == rxFAcycle && dIndex != rxFmpsIndex + 5'd1)
        seqFail = 1'b1;
    end
  end
`else
  assign seqFail = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    stateNext = state;
    decide    = 1'b0;
    code      = CODE_OK;
    latchHdr  = 1'b0;
    goodData  = 1'b0;
    reseed    = 1'b0;
    if (!auroraChannelUp) begin
      stateNext = WAIT_HEADER;
    end else if (beat) begin
      unique case (state)
        WAIT_HEADER: begin
          if (tlast) begin
            decide = 1'b1;
            code   = CODE_FRAMING;
          end else if (hdrBad) begin
            decide    = 1'b1;
            code      = CODE_HEADER;
            stateNext = DISCARD;
          end else begin
            latchHdr  = 1'b1;
            stateNext = WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          decide = 1'b1;
          if (!tlast) begin
            code      = CODE_FRAMING;
            stateNext = DISCARD;
          end else begin
            stateNext = WAIT_HEADER;
            if (dataBad) begin
              code = CODE_DATA;
            end else if (seqFail) begin
              code   = CODE_DATA;
              reseed = 1'b1;
            end else begin
              goodData = 1'b1;
            end
          end
        end
        DISCARD: if (tlast) stateNext = WAIT_HEADER;
        default: stateNext = WAIT_HEADER;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge auroraUserClk or negedge auroraReset_n) begin
    if (!auroraReset_n) begin
      state        <= WAIT_HEADER;
      hdrIndex     <= '0;
      statusStrobe <= 1'b0;
      statusCode   <= '0;
      rxFmpsIndex  <= '0;
      rxFAcycle    <= '0;
      goodCount    <= '0;
      errorCount   <= '0;
    end else begin
      state        <= stateNext;
      statusStrobe <= decide;
      if (decide)   statusCode <= code;
      if (latchHdr) hdrIndex   <= tdata[14:10];
      if (goodData || reseed) begin
        rxFmpsIndex <= dIndex;
        rxFAcycle   <= dCycle;
      end
      if (clearCounters) begin
        goodCount  <= '0;
        errorCount <= '0;
      end else if (decide) begin
        if (code == CODE_OK)     goodCount  <= goodCount + 32'd1;
        else if (errorCount != '1) errorCount <= errorCount + 1'b1;
      end
    end
  end

`ifdef SEQUENCE_CHECK_EN
  always_ff @(posedge auroraUserClk or negedge auroraReset_n) begin
    if (!auroraReset_n)        seeded <= 1'b0;
    else if (!auroraChannelUp) seeded <= 1'b0;
    else if (goodData)         seeded <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_read_fmps_test_link.sv
// Directed bench for read_fmps_test_link: expected strobes are queued as beats are driven
// and compared, with the counters and rx fields, whenever the DUT pulses statusStrobe.
module tb_read_fmps_test_link;

  localparam int EW = 8;  // narrow error counter so saturation is reachable quickly

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          chanUp = 1'b0;
  logic [31:0]   tdata = '0;
  logic          tvalid = 1'b0, tlast = 1'b0, clr = 1'b0;
  logic          tready, statusStrobe;
  logic [1:0]    statusCode, dbgState;
  logic [4:0]    rxFmpsIndex;
  logic [7:0]    rxFAcycle;
  logic [31:0]   goodCount;
  logic [EW-1:0] errorCount;

  read_fmps_test_link #(.ERR_COUNT_WIDTH(EW)) dut (
    .auroraUserClk(clk), .auroraReset_n(rst_n), .auroraChannelUp(chanUp),
    .FMPS_TEST_AXI_STREAM_RX_tdata(tdata), .FMPS_TEST_AXI_STREAM_RX_tvalid(tvalid),
    .FMPS_TEST_AXI_STREAM_RX_tlast(tlast), .FMPS_TEST_AXI_STREAM_RX_tready(tready),
    .clearCounters(clr), .statusStrobe(statusStrobe), .statusCode(statusCode),
    .rxFmpsIndex(rxFmpsIndex), .rxFAcycle(rxFAcycle), .goodCount(goodCount),
    .errorCount(errorCount), .dbgState(dbgState));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    code;
    logic [31:0]   good;
    logic [EW-1:0] err;
    logic [4:0]    idx;
    logic [7:0]    cyc;
  } exp_t;

  exp_t q[$];
  int nChecks = 0, nErrors = 0;
  logic [31:0]   mGood = '0;
  logic [EW-1:0] mErr = '0;
  logic [4:0]    mIdx = '0;
  logic [7:0]    mCyc = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Record the strobe a deciding beat must produce; counters follow the same edge.
  task automatic expect_code(input logic [1:0] code, input bit loadRx,
                             input logic [4:0] idx, input logic [7:0] cyc);
    exp_t e;
    if (clr) begin
      mGood = '0;
      mErr  = '0;
    end else if (code == 2'd0) mGood = mGood + 1;
    else if (mErr != {EW{1'b1}}) mErr = mErr + 1'b1;
    if (loadRx) begin
      mIdx = idx;
      mCyc = cyc;
    end
    e.code = code; e.good = mGood; e.err = mErr; e.idx = mIdx; e.cyc = mCyc;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && statusStrobe === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("statusCode", 32'(statusCode), 32'(e.code));
        check("goodCount", goodCount, e.good);
        check("errorCount", 32'(errorCount), 32'(e.err));
        check("rxFmpsIndex", 32'(rxFmpsIndex), 32'(e.idx));
        check("rxFAcycle", 32'(rxFAcycle), 32'(e.cyc));
      end
    end
  end

  function automatic logic [31:0] hdr(input logic [4:0] idx);
    return {16'hB6CF, 1'b1, idx, 10'h000};
  endfunction

  function automatic logic [31:0] dat(input logic [4:0] idx, input logic [7:0] cyc);
    return {3'b000, idx, 16'hCACA, cyc};
  endfunction

  // Inputs change 1 time unit after a rising edge; the beat is taken at the next edge.
  task automatic send(input logic [31:0] d, input logic l);
    tdata = d; tvalid = 1'b1; tlast = l;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic good_pkt(input logic [4:0] idx, input logic [7:0] cyc);
    send(hdr(idx), 1'b0);
    expect_code(2'd0, 1'b1, idx, cyc);
    send(dat(idx, cyc), 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_strobe", 32'(statusStrobe), 32'd0);
    check("reset_code", 32'(statusCode), 32'd0);
    check("reset_state", 32'(dbgState), 32'd0);
    check("reset_good", goodCount, 32'd0);
    check("reset_err", 32'(errorCount), 32'd0);
    check("reset_rx", {rxFmpsIndex, rxFAcycle}, 32'd0);
    check("tready_down", 32'(tready), 32'd0);
    rst_n = 1'b1;
    chanUp = 1'b1;
    #1 check("tready_up", 32'(tready), 32'd1);
    @(posedge clk); #1;

    // Good packet: header index 1, data cycle 0x07.
    send(hdr(5'd1), 1'b0);
    check("state_after_header", 32'(dbgState), 32'd1);
    expect_code(2'd0, 1'b1, 5'd1, 8'h07);
    send(dat(5'd1, 8'h07), 1'b1);
    check("state_after_data", 32'(dbgState), 32'd0);

    // Bad magic, then bad enable: one code 1 each, following data swallowed.
    expect_code(2'd1, 1'b0, '0, '0);
    send(32'h1234_8400, 1'b0);
    check("state_discard", 32'(dbgState), 32'd2);
    send(dat(5'd1, 8'h07), 1'b1);
    check("discard_exit", 32'(dbgState), 32'd0);
    expect_code(2'd1, 1'b0, '0, '0);
    send(32'hB6CF_0400, 1'b0);
    send(dat(5'd1, 8'h07), 1'b1);

    // Lone tlast beat in WAIT_HEADER: framing error, state unchanged.
    expect_code(2'd3, 1'b0, '0, '0);
    send(hdr(5'd1), 1'b1);
    check("framing_stay", 32'(dbgState), 32'd0);
    repeat (3) @(posedge clk);
    #1 check("code_holds", 32'(statusCode), 32'd3);

    // Data without tlast: framing error, discard until tlast, then recover.
    send(hdr(5'd1), 1'b0);
    expect_code(2'd3, 1'b0, '0, '0);
    send(dat(5'd1, 8'h08), 1'b0);
    send(dat(5'd1, 8'h08), 1'b0);
    send(dat(5'd1, 8'h08), 1'b1);
    good_pkt(5'd2, 8'h08);

    // Data field errors: pattern, index mismatch, nonzero top bits.
    send(hdr(5'd1), 1'b0);
    expect_code(2'd2, 1'b0, '0, '0);
    send({3'b000, 5'd1, 16'hCACB, 8'h09}, 1'b1);
    send(hdr(5'd1), 1'b0);
    expect_code(2'd2, 1'b0, '0, '0);
    send(dat(5'd2, 8'h09), 1'b1);
    send(hdr(5'd1), 1'b0);
    expect_code(2'd2, 1'b0, '0, '0);
    send(dat(5'd1, 8'h09) | 32'h2000_0000, 1'b1);
    good_pkt(5'd3, 8'h09);

    // Channel drops between header and data: no strobe, packet dropped.
    send(hdr(5'd4), 1'b0);
    chanUp = 1'b0;
    tdata = dat(5'd4, 8'h0A); tvalid = 1'b1; tlast = 1'b1;
    #1 check("tready_dropped", 32'(tready), 32'd0);
    @(posedge clk); #1;
    check("down_state", 32'(dbgState), 32'd0);
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
    chanUp = 1'b1;
    good_pkt(5'd7, 8'h20);

    // Reset mid-packet returns everything to zero immediately.
    send(hdr(5'd9), 1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_state", 32'(dbgState), 32'd0);
    check("midreset_good", goodCount, 32'd0);
    check("midreset_rx", {rxFmpsIndex, rxFAcycle}, 32'd0);
    mGood = '0; mErr = '0; mIdx = '0; mCyc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Header low bits are ignored.
    send(hdr(5'd8) | 32'h0000_03FF, 1'b0);
    expect_code(2'd0, 1'b1, 5'd8, 8'h21);
    send(dat(5'd8, 8'h21), 1'b1);

    // Error counter saturates at all-ones.
    for (int i = 0; i < (1 << EW) + 2; i++) begin
      expect_code(2'd3, 1'b0, '0, '0);
      send(hdr(5'd1), 1'b1);
    end
    @(negedge clk);
    check("err_saturated", 32'(errorCount), 32'(2 ** EW - 1));

    // Clear coincident with a strobe wins over the increment.
    clr = 1'b1;
    expect_code(2'd3, 1'b0, '0, '0);
    send(hdr(5'd1), 1'b1);
    clr = 1'b0;
    @(negedge clk);
    check("clear_err", 32'(errorCount), 32'd0);
    check("clear_good", goodCount, 32'd0);

    // Sequence: after channel-down the reference is unseeded again.
    chanUp = 1'b0;
    @(posedge clk); #1;
    chanUp = 1'b1;
    good_pkt(5'd1, 8'h07);
    good_pkt(5'd2, 8'h07);
    send(hdr(5'd3), 1'b0);
`ifdef SEQUENCE_CHECK_EN
    expect_code(2'd2, 1'b1, 5'd3, 8'h09);
`else
    expect_code(2'd0, 1'b1, 5'd3, 8'h09);
`endif
    send(dat(5'd3, 8'h09), 1'b1);

    repeat (5) @(posedge clk);
    #1 check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
